// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants, IF/ID register layout and next-PC select encoding.
// Imported by instruction_fetch and pc_next_logic.
package cpu_pkg;
    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc_plus4;
        logic               valid;
    } if_id_t;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_BRANCH,
        SEL_JUMP
    } pc_sel_e;

    // Branch offset is a word offset; turn it into a signed byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction
endpackage

// File: rtl/pc_next_logic.sv
// PC register plus next-PC mux (jump > branch > stall hold > sequential); one-cycle update.
// Redirects are resolved from the ID-stage fields and always win over stall.
module pc_next_logic
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_imm_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic [31:0] if_id_pc_plus4_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    pc_sel_e     sel;

    assign pc_plus4_o    = pc_q + 32'd4;
    assign branch_target = if_id_pc_plus4_i + branch_offset(branch_imm_i);
    assign jump_target   = {if_id_pc_plus4_i[31:28], jump_index_i, 2'b00};
    assign pc_o          = pc_q;

    always_comb begin
        sel = SEL_SEQ;
        if (jump_i)
            sel = SEL_JUMP;
        else if (branch_taken_i)
            sel = SEL_BRANCH;
        else if (stall_i)
            sel = SEL_HOLD;
    end

    always_comb begin
        pc_d = pc_plus4_o;
        case (sel)
            SEL_JUMP:   pc_d = jump_target;
            SEL_BRANCH: pc_d = branch_target;
            SEL_HOLD:   pc_d = pc_q;
            default:    pc_d = pc_plus4_o;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end
endmodule

// File: rtl/instruction_fetch.sv
// IF stage: combinational imem read at PC, IF/ID register loaded one clock later; redirect costs one bubble.
// stall holds PC and IF/ID; redirect/flush/fetch fault load a bubble; FETCH_PERF_CNT_EN adds fetch/bubble counters.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = 64
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [15:0]        branch_imm,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc_plus4,
    output logic               if_id_valid,
    output logic               fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
`endif
);
    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        bubble_ld;
    logic        fetch_ld;
    if_id_t      if_id_q;
    if_id_t      if_id_d;

    pc_next_logic #(
        .RESET_PC (RESET_PC)
    ) u_pc_next (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall),
        .branch_taken_i   (branch_taken),
        .branch_imm_i     (branch_imm),
        .jump_i           (jump),
        .jump_index_i     (jump_index),
        .if_id_pc_plus4_i (if_id_q.pc_plus4),
        .pc_o             (pc),
        .pc_plus4_o       (pc_plus4)
    );

    assign imem_addr   = pc;
    assign fetch_fault = (pc >= IMEM_BYTES);

    // A faulting fetch only turns into a bubble when the edge is not stalled.
    assign redirect  = jump | branch_taken;
    assign bubble_ld = redirect | flush | (~stall & fetch_fault);
    assign fetch_ld  = ~redirect & ~flush & ~stall & ~fetch_fault;

    always_comb begin
        if_id_d = if_id_q;
        if (bubble_ld) begin
            if_id_d.instr    = NOP_INSTR;
            if_id_d.pc_plus4 = 32'h0;
            if_id_d.valid    = 1'b0;
        end else if (fetch_ld) begin
            if_id_d.instr    = imem_instr;
            if_id_d.pc_plus4 = pc_plus4;
            if_id_d.valid    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            if_id_q <= '0;
        else
            if_id_q <= if_id_d;
    end

    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_valid    = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] fetched_d;
    logic [31:0] bubbles_q;
    logic [31:0] bubbles_d;

    assign fetched_d = fetched_q + {31'd0, fetch_ld};
    assign bubbles_d = bubbles_q + {31'd0, bubble_ld};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= 32'h0;
            bubbles_q <= 32'h0;
        end else begin
            fetched_q <= fetched_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif
endmodule
